// File: rtl/memory_block.sv
// ---------------------------------------------------------------------------
// memory_block
//   Word-addressed register memory with independent write and read ports.
//   Each port is a two-state (IDLE/WAIT) FSM with a programmable number of
//   wait states, so the block behaves like a slow peripheral RAM.
//
// Ports
//   clock    in   1             rising-edge clock
//   reset    in   1             asynchronous, active-low reset
//   w_en     in   1             write request (level-sensitive)
//   r_en     in   1             read request (level-sensitive)
//   w_addr   in   ADDRESS_SIZE  write address
//   r_addr   in   ADDRESS_SIZE  read address
//   w_data   in   WORD_SIZE     write data
//   r_data   out  WORD_SIZE     registered read data
//   r_ready  out  1             read port idle, r_data valid
//   w_ready  out  1             write port idle
//
// Build option
//   MEMORY_FORWARD_EN : when defined, a read completing on the same edge as a
//   write commit to the same in-range address returns the new write data.
//   When undefined the read returns the pre-write word and no bypass exists.
// ---------------------------------------------------------------------------
module memory_block #(
    parameter int                   WORD_SIZE    = 8,
    parameter logic [WORD_SIZE-1:0] WORD_INIT    = '0,
    parameter int                   ADDRESS_SIZE = 4,
    parameter int                   MEMORY_QTY   = 16,
    parameter int                   WAIT_SIZE    = 2,
    parameter int                   READ_WAIT    = 0,
    parameter int                   WRITE_WAIT   = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    w_en,
    input  logic                    r_en,
    input  logic [ADDRESS_SIZE-1:0] w_addr,
    input  logic [ADDRESS_SIZE-1:0] r_addr,
    input  logic [WORD_SIZE-1:0]    w_data,
    output logic [WORD_SIZE-1:0]    r_data,
    output logic                    r_ready,
    output logic                    w_ready
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [WAIT_SIZE-1:0]  RW  = WAIT_SIZE'(READ_WAIT);
    localparam logic [WAIT_SIZE-1:0]  WW  = WAIT_SIZE'(WRITE_WAIT);
    // One extra bit so MEMORY_QTY == 2**ADDRESS_SIZE is representable.
    localparam logic [ADDRESS_SIZE:0] QTY = (ADDRESS_SIZE+1)'(MEMORY_QTY);

    logic [WORD_SIZE-1:0]    mem_q [MEMORY_QTY];

    // Write port
    state_t                  w_state_q;
    logic [WAIT_SIZE-1:0]    w_cnt_q, w_cnt_d;
    logic [ADDRESS_SIZE-1:0] w_addr_q;
    logic [WORD_SIZE-1:0]    w_data_q;
    logic                    w_ready_q;
    logic                    w_done;
    logic                    w_in_range;

    // Read port
    state_t                  r_state_q;
    logic [WAIT_SIZE-1:0]    r_cnt_q, r_cnt_d;
    logic [ADDRESS_SIZE-1:0] r_addr_q;
    logic [WORD_SIZE-1:0]    r_data_q;
    logic                    r_ready_q;
    logic                    r_done;
    logic                    r_in_range;
    logic [WORD_SIZE-1:0]    r_word;

    assign w_done     = (w_state_q == ST_WAIT) && (w_cnt_q == WW);
    assign w_in_range = {1'b0, w_addr_q} < QTY;
    assign w_cnt_d    = w_cnt_q + 1'b1;

    assign r_done     = (r_state_q == ST_WAIT) && (r_cnt_q == RW);
    assign r_in_range = {1'b0, r_addr_q} < QTY;
    assign r_cnt_d    = r_cnt_q + 1'b1;

    // Word returned on read completion. Out-of-range reads see WORD_INIT.
    always_comb begin
        r_word = r_in_range ? mem_q[r_addr_q] : WORD_INIT;
`ifdef MEMORY_FORWARD_EN
        // Bypass the commit happening on this same edge.
        if (w_done && w_in_range && (w_addr_q == r_addr_q))
            r_word = w_data_q;
`endif
    end

    // Write FSM owns the storage array; an aborted WAIT never commits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state_q <= ST_IDLE;
            w_cnt_q   <= '0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            w_ready_q <= 1'b1;
            for (int i = 0; i < MEMORY_QTY; i++)
                mem_q[i] <= WORD_INIT;
        end else begin
            case (w_state_q)
                ST_IDLE: begin
                    if (w_en) begin
                        w_addr_q  <= w_addr;
                        w_data_q  <= w_data;
                        w_cnt_q   <= '0;
                        w_ready_q <= 1'b0;
                        w_state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_done) begin
                        // Out-of-range writes still handshake but are dropped.
                        if (w_in_range)
                            mem_q[w_addr_q] <= w_data_q;
                        w_ready_q <= 1'b1;
                        w_state_q <= ST_IDLE;
                    end else begin
                        w_cnt_q <= w_cnt_d;
                    end
                end
                default: w_state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
            r_data_q  <= WORD_INIT;
            r_ready_q <= 1'b1;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (r_en) begin
                        r_addr_q  <= r_addr;
                        r_cnt_q   <= '0;
                        r_ready_q <= 1'b0;
                        r_state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_done) begin
                        r_data_q  <= r_word;
                        r_ready_q <= 1'b1;
                        r_state_q <= ST_IDLE;
                    end else begin
                        r_cnt_q <= r_cnt_d;
                    end
                end
                default: r_state_q <= ST_IDLE;
            endcase
        end
    end

    assign r_data  = r_data_q;
    assign r_ready = r_ready_q;
    assign w_ready = w_ready_q;

endmodule

// File: tb/tb_memory_block.sv
// Bench for memory_block. Three instances share clock and reset:
//   0: default parameters
//   1: READ_WAIT=2, WRITE_WAIT=3
//   2: MEMORY_QTY=12
// A plain array per instance models the memory contents; handshake lengths
// are checked against WAIT+1 cycles.
module tb_memory_block;

    logic       clock;
    logic       rst_n;
    logic [2:0] w_en, r_en, w_rdy, r_rdy;
    logic [3:0] w_addr [3];
    logic [3:0] r_addr [3];
    logic [7:0] w_data [3];
    logic [7:0] r_data [3];

    int n_tests = 0;
    int n_fail  = 0;
    int mdl [3][16];
    int qty [3] = '{16, 16, 12};
    int rwt [3] = '{0, 2, 0};
    int wwt [3] = '{0, 3, 0};

    memory_block u_def (
        .clock(clock), .reset(rst_n), .w_en(w_en[0]), .r_en(r_en[0]),
        .w_addr(w_addr[0]), .r_addr(r_addr[0]), .w_data(w_data[0]),
        .r_data(r_data[0]), .r_ready(r_rdy[0]), .w_ready(w_rdy[0])
    );

    memory_block #(.READ_WAIT(2), .WRITE_WAIT(3)) u_ws (
        .clock(clock), .reset(rst_n), .w_en(w_en[1]), .r_en(r_en[1]),
        .w_addr(w_addr[1]), .r_addr(r_addr[1]), .w_data(w_data[1]),
        .r_data(r_data[1]), .r_ready(r_rdy[1]), .w_ready(w_rdy[1])
    );

    memory_block #(.MEMORY_QTY(12)) u_qty (
        .clock(clock), .reset(rst_n), .w_en(w_en[2]), .r_en(r_en[2]),
        .w_addr(w_addr[2]), .r_addr(r_addr[2]), .w_data(w_data[2]),
        .r_data(r_data[2]), .r_ready(r_rdy[2]), .w_ready(w_rdy[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    function automatic int expect_rd(input int k, input int a);
        return (a < qty[k]) ? mdl[k][a] : 0;
    endfunction

    // Called and returns on a negedge.
    task automatic do_write(input int k, input int a, input int d);
        int n;
        n = 0;
        while (!w_rdy[k] && n < 20) begin @(negedge clock); n++; end
        w_en[k] = 1'b1; w_addr[k] = a[3:0]; w_data[k] = d[7:0];
        @(posedge clock); @(negedge clock);
        w_en[k] = 1'b0;
        n = 0;
        while (!w_rdy[k] && n < 20) begin n++; @(negedge clock); end
        n_tests++;
        if (n != wwt[k] + 1) begin
            n_fail++;
            $display("FAIL w_ready_low inst%0d addr %0d: got %0d cycles, want %0d", k, a, n, wwt[k] + 1);
        end
        if (a < qty[k]) mdl[k][a] = d;
    endtask

    task automatic do_read(input int k, input int a);
        int n;
        int exp;
        n = 0;
        while (!r_rdy[k] && n < 20) begin @(negedge clock); n++; end
        r_en[k] = 1'b1; r_addr[k] = a[3:0];
        @(posedge clock); @(negedge clock);
        r_en[k] = 1'b0;
        n = 0;
        while (!r_rdy[k] && n < 20) begin n++; @(negedge clock); end
        n_tests++;
        if (n != rwt[k] + 1) begin
            n_fail++;
            $display("FAIL r_ready_low inst%0d addr %0d: got %0d cycles, want %0d", k, a, n, rwt[k] + 1);
        end
        exp = expect_rd(k, a);
        n_tests++;
        if (r_data[k] !== 8'(exp)) begin
            n_fail++;
            $display("FAIL read_data inst%0d addr %0d: got %02h, want %02h", k, a, r_data[k], exp[7:0]);
        end
    endtask

    task automatic test_power_on;
        n_tests++;
        if (w_rdy !== 3'b111 || r_rdy !== 3'b111) begin
            n_fail++;
            $display("FAIL power_on_ready: got w=%b r=%b, want 111/111", w_rdy, r_rdy);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (r_data[k] !== 8'h00) begin
                n_fail++;
                $display("FAIL power_on_rdata inst%0d: got %02h, want 00", k, r_data[k]);
            end
        end
    endtask

    task automatic test_basic;
        do_write(0, 3, 'hA5);
        do_read(0, 3);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) do_write(0, $urandom_range(0, 15), $urandom_range(0, 255));
            else                           do_read(0, $urandom_range(0, 15));
        end
    endtask

    task automatic test_waits;
        for (int i = 0; i < 12; i++) begin
            if ((i % 2) == 0) do_write(1, $urandom_range(0, 15), $urandom_range(0, 255));
            else              do_read(1, $urandom_range(0, 15));
        end
        do_write(1, 9, 'h5C);
        do_read(1, 9);
    endtask

    task automatic test_back_to_back;
        logic [3:0] a;
        int n;
        for (int i = 0; i < 16; i++) do_write(0, i, i + 1);
        a = 4'd0;
        r_en[0] = 1'b1; r_addr[0] = a;
        for (int i = 0; i < 17; i++) begin
            @(posedge clock); @(negedge clock);
            n_tests++;
            if (r_rdy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_accept step %0d: got r_ready %b, want 0", i, r_rdy[0]);
            end
            n = 0;
            while (!r_rdy[0] && n < 20) begin n++; @(negedge clock); end
            n_tests++;
            if (r_data[0] !== 8'(mdl[0][a]) || n != 1) begin
                n_fail++;
                $display("FAIL b2b_read addr %0d: got %02h after %0d cycles, want %02h after 1",
                         a, r_data[0], n, mdl[0][a]);
            end
            a = a + 4'd1;
            r_addr[0] = a;
        end
        r_en[0] = 1'b0;
        @(negedge clock);
    endtask

    // Write and read accepted on one edge complete together on the next.
    task automatic test_same_edge;
        int exp;
        int aw, ar, dw;
        do_write(0, 5, 'h3C);
        w_en[0] = 1'b1; w_addr[0] = 4'd5; w_data[0] = 8'h77;
        r_en[0] = 1'b1; r_addr[0] = 4'd5;
        @(posedge clock); @(negedge clock);
        w_en[0] = 1'b0; r_en[0] = 1'b0;
        @(negedge clock);
`ifdef MEMORY_FORWARD_EN
        exp = 'h77;
`else
        exp = 'h3C;
`endif
        n_tests++;
        if (r_data[0] !== 8'(exp) || r_rdy[0] !== 1'b1 || w_rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL same_edge_rdata: got %02h rdy %b/%b, want %02h rdy 1/1",
                     r_data[0], r_rdy[0], w_rdy[0], exp[7:0]);
        end
        mdl[0][5] = 'h77;
        do_read(0, 5);
        // Concurrent traffic to different addresses must not interact.
        for (int i = 0; i < 8; i++) begin
            aw = $urandom_range(0, 15);
            ar = (aw + $urandom_range(1, 15)) % 16;
            dw = $urandom_range(0, 255);
            w_en[0] = 1'b1; w_addr[0] = aw[3:0]; w_data[0] = dw[7:0];
            r_en[0] = 1'b1; r_addr[0] = ar[3:0];
            @(posedge clock); @(negedge clock);
            w_en[0] = 1'b0; r_en[0] = 1'b0;
            @(negedge clock);
            n_tests++;
            if (r_data[0] !== 8'(mdl[0][ar])) begin
                n_fail++;
                $display("FAIL concurrent_read w%0d r%0d: got %02h, want %02h", aw, ar, r_data[0], mdl[0][ar]);
            end
            mdl[0][aw] = dw;
        end
        do_read(0, aw);
    endtask

    task automatic test_range;
        for (int i = 0; i < 12; i++) do_write(2, i, $urandom_range(0, 255));
        do_write(2, 13, 'h5A);
        do_write(2, 12, 'hC3);
        do_read(2, 13);
        do_read(2, 12);
        for (int i = 0; i < 12; i++) do_read(2, i);
    endtask

    // Reset in the middle of a slow write: nothing may be committed.
    task automatic test_reset;
        w_en[1] = 1'b1; w_addr[1] = 4'd2; w_data[1] = 8'hFF;
        @(posedge clock); @(negedge clock);
        w_en[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (w_rdy !== 3'b111 || r_rdy !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_ready: got w=%b r=%b, want 111/111", w_rdy, r_rdy);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (r_data[k] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_rdata inst%0d: got %02h, want 00", k, r_data[k]);
            end
        end
        @(negedge clock);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 16; a++) mdl[k][a] = 0;
        for (int a = 0; a < 16; a++) do_read(0, a);
        do_read(1, 2);
        do_read(2, 5);
    endtask

    initial begin
        rst_n = 1'b0;
        w_en = '0; r_en = '0;
        for (int k = 0; k < 3; k++) begin
            w_addr[k] = '0; r_addr[k] = '0; w_data[k] = '0;
            for (int a = 0; a < 16; a++) mdl[k][a] = 0;
        end
        repeat (2) @(negedge clock);
        test_power_on;
        rst_n = 1'b1;
        @(negedge clock);
        test_basic;
        test_random;
        test_waits;
        test_back_to_back;
        test_same_edge;
        test_range;
        test_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
